wr_ctrl_sync: RTL and testbench
===============================

Name: wr_ctrl_sync

Overview:
Parametrised write-side controller for the dual-clock FIFO, running entirely in the w_clk domain. It owns the write pointer, the memory write address and enable, and the full and almost-full flags. It also reports fill level. It contains its own read-pointer synchronizer, with a configurable stage count, and registers every status output. It drives the FIFO memory write port and publishes a registered Gray-coded write pointer to the read-side controller.

Parameters:
- ADDR_WIDTH, 4, memory address width. Depth is 2**ADDR_WIDTH. Legal range is ADDR_WIDTH >= 1.
- SYNC_STAGES, 2, number of flop stages synchronizing r_ptr_gray into w_clk. Legal range is SYNC_STAGES >= 2.

Ports:
- w_clk, input, 1, write-domain clock.
- w_rst, input, 1, reset: asynchronous, active-low.
- winc, input, 1, write request from the producer.
- af_thresh, input, ADDR_WIDTH+1, almost-full threshold in words. Quasi-static.
- r_ptr_gray, input, ADDR_WIDTH+1, Gray-coded read pointer from the r_clk domain. Asynchronous to w_clk.
- wen, output, 1, memory write enable.
- waddr, output, ADDR_WIDTH, memory write address.
- w_ptr_gray, output, ADDR_WIDTH+1, registered Gray-coded write pointer, sent to the read domain.
- wfull, output, 1, FIFO full.
- walmost_full, output, 1, level >= af_thresh.
- wlevel, output, ADDR_WIDTH+1, words stored, as seen from the write domain.
- wovf, output, 1, overflow error (only when WR_CTRL_OVF_EN is defined).
- wovf_clr, input, 1, clears wovf (only when WR_CTRL_OVF_EN is defined).

Behaviour:
- Reset (w_rst low, asynchronous):
  - Binary pointer, Gray pointer and all synchronizer stages clear to 0.
  - wfull, walmost_full, wlevel and wovf clear to 0.
  - If reset is asserted mid-operation, all state is lost at once, with no completion of an in-flight write.
- Accepting a write:
  - wen = winc & ~wfull, combinational from registered wfull.
  - waddr = wbin[ADDR_WIDTH-1:0], the current binary pointer (not the next one).
  - wbin_next = wbin + wen, computed modulo 2**(ADDR_WIDTH+1). The extra MSB is the wrap bit.
- Pointer registers:
  - On each w_clk edge: wbin <= wbin_next, and w_ptr_gray <= wbin_next ^ (wbin_next >> 1).
  - w_ptr_gray changes by at most one bit per cycle.
- Read-pointer synchronization:
  - r_ptr_gray passes through SYNC_STAGES flops to give rq_gray. No logic is allowed before the first flop.
  - rbin_sync = Gray-to-binary of rq_gray (prefix XOR from the MSB down).
- Level and flags, computed from next-state values so they are valid in the same cycle as the pointer:
  - lvl_next = wbin_next - rbin_sync, modulo 2**(ADDR_WIDTH+1).
  - wlevel <= lvl_next.
  - wfull <= (lvl_next == 2**ADDR_WIDTH).
  - walmost_full <= (lvl_next >= af_thresh).
  - af_thresh = 0 forces walmost_full high. af_thresh > depth forces it permanently low.
- Latency:
  - A write that fills the FIFO sets wfull on the same edge that commits it. No write can overrun.
  - A read-side pop reaches wlevel and wfull after SYNC_STAGES+1 w_clk edges. This is a pessimistic but safe deassertion.
- Boundary conditions:
  - winc while wfull = 1: the write is dropped. wen = 0 and the pointer holds.
  - Full and empty are distinguished by the wrap bit. lvl_next never exceeds 2**ADDR_WIDTH.
  - Wrap-around: the pointer goes from 2**(ADDR_WIDTH+1)-1 to 0 with no glitch in level or flags.
  - Simultaneous write and remote pop on the same cycle: level is computed from both the new wbin and the new rbin_sync.

Optional Feature:
- Macro: WR_CTRL_OVF_EN.
- When defined:
  - wovf and wovf_clr ports exist.
  - wovf <= 1 when winc & wfull. It is sticky until wovf_clr = 1 or reset.
  - If the set and clear conditions occur on the same cycle, set wins.
- When undefined:
  - The wovf and wovf_clr ports are absent.
  - Dropped writes are silent.

Test Plan (ADDR_WIDTH = 4, SYNC_STAGES = 2):
- Write 16 words with r_ptr_gray held at 0, af_thresh = 12:
  - walmost_full rises on the edge committing word 12.
  - wfull rises on the edge committing word 16, with wlevel = 16.
  - wen = 0 thereafter.
  - waddr sequence is 0..15.
- From full, winc held high for 5 cycles:
  - No wen, wbin unchanged, wlevel stays 16.
  - With WR_CTRL_OVF_EN: wovf = 1 after the first cycle, and it clears one cycle after wovf_clr is pulsed.
- From full, change r_ptr_gray to gray(1):
  - wfull drops and wlevel = 15 exactly 3 w_clk edges later.
  - The next winc is accepted with waddr = 0.
- Run 40 write/read round-trips:
  - Pointer wraps from 31 to 0.
  - w_ptr_gray shows Hamming distance 1 on every change, and the flags stay correct across the wrap.
- Assert w_rst low mid-burst, asynchronously relative to w_clk:
  - All outputs go to 0 immediately, and the next write after release goes to waddr = 0.
- ADDR_WIDTH = 1, SYNC_STAGES = 3:
  - wfull after 2 writes.
  - Deassertion latency of 4 edges after a remote pop.

Source files
------------

// File: rtl/wr_ctrl_sync.sv
// Write-side controller for the dual-clock FIFO: write pointer, read-pointer synchronizer, registered flags.
// Define WR_CTRL_OVF_EN to build the sticky overflow flag (wovf / wovf_clr ports).
module wr_ctrl_sync #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   r_ptr_gray,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   w_ptr_gray,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel
`ifdef WR_CTRL_OVF_EN
    ,
    output logic                  wovf,
    input  logic                  wovf_clr
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0] wbin;
    logic [ADDR_WIDTH:0] wbin_next;
    logic [ADDR_WIDTH:0] rq_gray;
    logic [ADDR_WIDTH:0] rbin_sync;
    logic [ADDR_WIDTH:0] lvl_next;
    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];

    assign wen       = winc & ~wfull;
    assign waddr     = wbin[ADDR_WIDTH-1:0];
    assign wbin_next = wbin + {{ADDR_WIDTH{1'b0}}, wen};

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wbin       <= '0;
            w_ptr_gray <= '0;
        end else begin
            wbin       <= wbin_next;
            w_ptr_gray <= wbin_next ^ (wbin_next >> 1);
        end
    end

    // First stage samples the foreign-domain pointer directly, no logic in front.
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= r_ptr_gray;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        rbin_sync = '0;
        for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
            rbin_sync[i] = ^(rq_gray >> i);
        end
    end

    // Flags use next-state pointer so a filling write raises wfull on its own edge.
    assign lvl_next = wbin_next - rbin_sync;

    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wlevel       <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= lvl_next;
            wfull        <= (lvl_next == DEPTH);
            walmost_full <= (lvl_next >= af_thresh);
        end
    end

`ifdef WR_CTRL_OVF_EN
    always_ff @(posedge w_clk or negedge w_rst) begin
        if (!w_rst) begin
            wovf <= 1'b0;
        end else if (winc && wfull) begin
            wovf <= 1'b1;
        end else if (wovf_clr) begin
            wovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_wr_ctrl_sync.sv
// Directed bench for wr_ctrl_sync: fill, drop-on-full, pop latency, wrap, async reset, and a 1-bit/3-stage instance.
module tb_wr_ctrl_sync;

    logic       w_clk;
    logic       w_rst;

    logic       winc;
    logic [4:0] af_thresh;
    logic [4:0] r_ptr_gray;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] w_ptr_gray;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;

    logic       winc_b;
    logic [1:0] af_thresh_b;
    logic [1:0] r_ptr_gray_b;
    logic       wen_b;
    logic [0:0] waddr_b;
    logic [1:0] w_ptr_gray_b;
    logic       wfull_b;
    logic       walmost_full_b;
    logic [1:0] wlevel_b;

`ifdef WR_CTRL_OVF_EN
    logic       wovf;
    logic       wovf_clr;
    logic       wovf_b;
    logic       wovf_clr_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    wr_ctrl_sync #(.ADDR_WIDTH(4), .SYNC_STAGES(2)) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .winc         (winc),
        .af_thresh    (af_thresh),
        .r_ptr_gray   (r_ptr_gray),
        .wen          (wen),
        .waddr        (waddr),
        .w_ptr_gray   (w_ptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel)
`ifdef WR_CTRL_OVF_EN
        ,
        .wovf         (wovf),
        .wovf_clr     (wovf_clr)
`endif
    );

    wr_ctrl_sync #(.ADDR_WIDTH(1), .SYNC_STAGES(3)) dut_b (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .winc         (winc_b),
        .af_thresh    (af_thresh_b),
        .r_ptr_gray   (r_ptr_gray_b),
        .wen          (wen_b),
        .waddr        (waddr_b),
        .w_ptr_gray   (w_ptr_gray_b),
        .wfull        (wfull_b),
        .walmost_full (walmost_full_b),
        .wlevel       (wlevel_b)
`ifdef WR_CTRL_OVF_EN
        ,
        .wovf         (wovf_b),
        .wovf_clr     (wovf_clr_b)
`endif
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leaves the bench 1 time unit after a rising edge.
    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [4:0] wptr;
    logic [4:0] rptr;
    logic [4:0] prev_gray;

    initial begin
        w_rst        = 1'b0;
        winc         = 1'b0;
        af_thresh    = 5'd12;
        r_ptr_gray   = '0;
        winc_b       = 1'b0;
        af_thresh_b  = 2'd1;
        r_ptr_gray_b = '0;
`ifdef WR_CTRL_OVF_EN
        wovf_clr     = 1'b0;
        wovf_clr_b   = 1'b0;
`endif
        #12;
        check("rst_wlevel", wlevel, 0);
        check("rst_wfull", wfull, 0);
        check("rst_walmost", walmost_full, 0);
        check("rst_gray", w_ptr_gray, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wen", wen, 0);
        w_rst = 1'b1;
        step();

        for (int k = 0; k < 16; k++) begin
            winc = 1'b1;
            #1;
            check("fill_wen", wen, 1);
            check("fill_waddr", waddr, k);
            step();
            check("fill_wlevel", wlevel, k + 1);
            check("fill_walmost", walmost_full, (k + 1 >= 12) ? 1 : 0);
            check("fill_wfull", wfull, (k + 1 == 16) ? 1 : 0);
            check("fill_gray", w_ptr_gray, gray5(5'(k + 1)));
        end

        for (int c = 0; c < 5; c++) begin
            #1;
            check("drop_wen", wen, 0);
            check("drop_waddr", waddr, 0);
            step();
            check("drop_wlevel", wlevel, 16);
            check("drop_wfull", wfull, 1);
            check("drop_gray", w_ptr_gray, 5'd24);
`ifdef WR_CTRL_OVF_EN
            check("ovf_set", wovf, 1);
`endif
        end
        winc = 1'b0;
`ifdef WR_CTRL_OVF_EN
        step();
        check("ovf_sticky", wovf, 1);
        wovf_clr = 1'b1;
        step();
        wovf_clr = 1'b0;
        check("ovf_clr", wovf, 0);
`endif

        r_ptr_gray = gray5(5'd1);
        for (int e = 1; e <= 3; e++) begin
            step();
            check("pop_wfull", wfull, (e < 3) ? 1 : 0);
            check("pop_wlevel", wlevel, (e < 3) ? 16 : 15);
        end
        winc = 1'b1;
        #1;
        check("pop_wen", wen, 1);
        check("pop_waddr", waddr, 0);
        step();
        winc = 1'b0;
        check("refill_wlevel", wlevel, 16);
        check("refill_wfull", wfull, 1);

        wptr = 5'd17;
        rptr = 5'd1;
        af_thresh = 5'd16;
        for (int i = 0; i < 40; i++) begin
            rptr = rptr + 5'd1;
            r_ptr_gray = gray5(rptr);
            prev_gray = w_ptr_gray;
            step();
            step();
            check("rt_full_hold", wfull, 1);
            step();
            check("rt_pop_wlevel", wlevel, 15);
            check("rt_pop_wfull", wfull, 0);
            check("rt_pop_walmost", walmost_full, 0);
            check("rt_pop_gray", w_ptr_gray, prev_gray);
            winc = 1'b1;
            #1;
            check("rt_wen", wen, 1);
            check("rt_waddr", waddr, wptr[3:0]);
            step();
            winc = 1'b0;
            wptr = wptr + 5'd1;
            check("rt_hamming", $countones(prev_gray ^ w_ptr_gray), 1);
            check("rt_gray", w_ptr_gray, gray5(wptr));
            check("rt_wlevel", wlevel, 16);
            check("rt_wfull", wfull, 1);
            check("rt_walmost", walmost_full, 1);
        end

        af_thresh = 5'd12;
        rptr = rptr + 5'd8;
        r_ptr_gray = gray5(rptr);
        step();
        step();
        step();
        check("pre_rst_wlevel", wlevel, 8);
        winc = 1'b1;
        step();
        step();
        #2;
        w_rst = 1'b0;
        winc = 1'b0;
        r_ptr_gray = '0;
        #1;
        check("arst_wlevel", wlevel, 0);
        check("arst_wfull", wfull, 0);
        check("arst_walmost", walmost_full, 0);
        check("arst_gray", w_ptr_gray, 0);
        check("arst_waddr", waddr, 0);
        check("arst_wen", wen, 0);
        #3;
        w_rst = 1'b1;
        af_thresh = 5'd0;
        step();
        check("af0_walmost", walmost_full, 1);
        check("af0_wlevel", wlevel, 0);
        af_thresh = 5'd12;
        winc = 1'b1;
        #1;
        check("post_rst_wen", wen, 1);
        check("post_rst_waddr", waddr, 0);
        step();
        winc = 1'b0;
        check("post_rst_wlevel", wlevel, 1);
        check("post_rst_walmost", walmost_full, 0);
        check("post_rst_gray", w_ptr_gray, 1);

        winc_b = 1'b1;
        #1;
        check("b_wen0", wen_b, 1);
        check("b_waddr0", waddr_b, 0);
        step();
        check("b_wlevel1", wlevel_b, 1);
        check("b_wfull1", wfull_b, 0);
        check("b_walmost1", walmost_full_b, 1);
        #1;
        check("b_wen1", wen_b, 1);
        check("b_waddr1", waddr_b, 1);
        step();
        check("b_wlevel2", wlevel_b, 2);
        check("b_wfull2", wfull_b, 1);
        #1;
        check("b_drop_wen", wen_b, 0);
        winc_b = 1'b0;
        r_ptr_gray_b = 2'b01;
        for (int e = 1; e <= 4; e++) begin
            step();
            check("b_pop_wfull", wfull_b, (e < 4) ? 1 : 0);
            check("b_pop_wlevel", wlevel_b, (e < 4) ? 2 : 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
